// File: rtl/dpram_pkg.sv
// Shared constants and byte-lane merge helper for the dual-port byte-enable RAM.
// The merge works on a fixed-size container so it can serve any supported word width.
package dpram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int MERGE_MAX_W = 256;
  localparam int MERGE_IDX_W = $clog2(MERGE_MAX_W);

  function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] din,
    input logic [MERGE_MAX_W-1:0] be,
    input int                     byte_w
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int k = 0; k < MERGE_MAX_W; k++) begin
      if (be[MERGE_IDX_W'(k / byte_w)]) res[k] = din[k];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_out_stage.sv
// Per-port read result register with an optional second pipeline stage.
// Valid tracks every access; data only reloads when the port produces a new word.
module dpram_out_stage
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  acc,
  input  logic                  upd,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid
);

  logic [DATA_WIDTH-1:0] d1;
  logic                  v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= acc;
      if (upd) d1 <= rdata;
    end
  end

  if (OUT_REG != 0) begin : g_reg
    logic [DATA_WIDTH-1:0] d2;
    logic                  v2;

    // d1 only changes on an access, so copying it whenever v1 is set keeps d2 one cycle behind.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= d1;
      end
    end

    assign dout  = d2;
    assign valid = v2;
  end else begin : g_noreg
    assign dout  = d1;
    assign valid = v1;
  end

endmodule

// File: rtl/dual_port_byte_ram.sv
// True dual-port RAM with byte enables, selectable read-during-write behaviour and
// same-address write collision flag. Port A owns any byte lane both ports write.
module dual_port_byte_ram
  import dpram_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 8,
  parameter  int BYTE_WIDTH = 8,
  parameter  int RDW_MODE   = 0,
  parameter  int OUT_REG    = 0,
  localparam int NB         = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [NB-1:0]         a_be,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [NB-1:0]         b_be,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid,
  output logic                  collision
);

  // Handshake: each access (en=1 on a rising edge) yields exactly one cycle of valid
  // with its dout after the fixed read latency; there is no ready, results never stall.

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_wr, b_wr, wr_same;
  logic [DATA_WIDTH-1:0] a_old, b_old;
  logic [DATA_WIDTH-1:0] a_merged, b_merged, ab_merged;
  logic [DATA_WIDTH-1:0] a_rdata, b_rdata;
  logic                  a_upd, b_upd;

  // Writes are masked while reset is held; the array itself is never cleared.
  assign a_wr    = a_en & a_we & rst_n;
  assign b_wr    = b_en & b_we & rst_n;
  assign wr_same = a_wr & b_wr & (a_addr == b_addr);

  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  assign a_merged  = DATA_WIDTH'(merge_bytes(MERGE_MAX_W'(a_old), MERGE_MAX_W'(a_din),
                                             MERGE_MAX_W'(a_be), BYTE_WIDTH));
  assign b_merged  = DATA_WIDTH'(merge_bytes(MERGE_MAX_W'(b_old), MERGE_MAX_W'(b_din),
                                             MERGE_MAX_W'(b_be), BYTE_WIDTH));
  // Same-address case: lay A's lanes over B's result so A wins every lane it enables.
  assign ab_merged = DATA_WIDTH'(merge_bytes(MERGE_MAX_W'(b_merged), MERGE_MAX_W'(a_din),
                                             MERGE_MAX_W'(a_be), BYTE_WIDTH));

  always_ff @(posedge clk) begin
    if (wr_same) begin
      mem[a_addr] <= ab_merged;
    end else begin
      if (a_wr) mem[a_addr] <= a_merged;
      if (b_wr) mem[b_addr] <= b_merged;
    end
  end

  // Cross-port reads see the pre-write word because the array updates after this edge.
  always_comb begin
    a_rdata = a_old;
    b_rdata = b_old;
    a_upd   = a_en;
    b_upd   = b_en;
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      if (a_we) a_rdata = a_merged;
      if (b_we) b_rdata = b_merged;
    end
    if (RDW_MODE == RDW_NO_CHANGE) begin
      if (a_we) a_upd = 1'b0;
      if (b_we) b_upd = 1'b0;
    end
  end

  dpram_out_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_REG   (OUT_REG)
  ) u_out_a (
    .clk  (clk),
    .rst_n(rst_n),
    .acc  (a_en),
    .upd  (a_upd),
    .rdata(a_rdata),
    .dout (a_dout),
    .valid(a_valid)
  );

  dpram_out_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_REG   (OUT_REG)
  ) u_out_b (
    .clk  (clk),
    .rst_n(rst_n),
    .acc  (b_en),
    .upd  (b_upd),
    .rdata(b_rdata),
    .dout (b_dout),
    .valid(b_valid)
  );

  // Flags any same-address dual write, even when the byte enables are disjoint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else        collision <= wr_same;
  end

endmodule

// File: tb/tb_dual_port_byte_ram.sv
// Bench for dual_port_byte_ram: four RDW_MODE/OUT_REG variants share one stimulus stream,
// each with its own word-level reference model, expected queues and monitor.
module tb_dual_port_byte_ram;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int NB    = 4;
  localparam int DEPTH = 256;
  localparam int NCFG  = 4;
  localparam int EW    = 1 + DW + 32;  // {care, data, due_time}

  logic          clk;
  logic          rst_n;
  logic          a_en, a_we, b_en, b_we;
  logic [NB-1:0] a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;
  logic          done;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int cfg,
                       input logic [DW-1:0] got, input logic [DW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cfg%0d at %0t: got %h expected %h", name, cfg, $time, got, want);
    end
  endtask

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  // ---------------- per-configuration DUT, model and monitor ----------------
  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int RM  = (gi == 1) ? 1 : (gi >= 2) ? 2 : 0;
    localparam int ORG = (gi == 1 || gi == 2) ? 1 : 0;
    localparam int LAT = (ORG != 0) ? 15 : 5;

    logic [DW-1:0] a_dout, b_dout;
    logic          a_valid, b_valid, collision;

    dual_port_byte_ram #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .BYTE_WIDTH(8),
      .RDW_MODE  (RM),
      .OUT_REG   (ORG)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a_en     (a_en),
      .a_we     (a_we),
      .a_be     (a_be),
      .a_addr   (a_addr),
      .a_din    (a_din),
      .a_dout   (a_dout),
      .a_valid  (a_valid),
      .b_en     (b_en),
      .b_we     (b_we),
      .b_be     (b_be),
      .b_addr   (b_addr),
      .b_din    (b_din),
      .b_dout   (b_dout),
      .b_valid  (b_valid),
      .collision(collision)
    );

    logic [DW-1:0] ref_mem [DEPTH];
    logic          known   [DEPTH];
    logic [DW-1:0] last_a, last_b, shown_a, shown_b;
    logic          care_a, care_b, shown_a_care, shown_b_care;
    logic [EW-1:0] exp_a_q[$];
    logic [EW-1:0] exp_b_q[$];
    logic [EW-1:0] exp_c_q[$];

    initial begin
      for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
      last_a = '0; last_b = '0; care_a = 1'b1; care_b = 1'b1;
      shown_a = '0; shown_b = '0; shown_a_care = 1'b1; shown_b_care = 1'b1;
    end

    // Reset discards everything in flight; outputs return to zero.
    always @(negedge rst_n) begin
      exp_a_q.delete(); exp_b_q.delete(); exp_c_q.delete();
      last_a = '0; last_b = '0; care_a = 1'b1; care_b = 1'b1;
      shown_a = '0; shown_b = '0; shown_a_care = 1'b1; shown_b_care = 1'b1;
    end

    // Reference model: one step per rising edge, word-level behaviour of the RAM.
    always @(posedge clk) begin : model
      logic [DW-1:0] old_a, old_b, res;
      logic          ka, kb, rc;
      logic [31:0]   t;
      if (rst_n) begin
        t     = 32'($time);
        old_a = ref_mem[a_addr]; ka = known[a_addr];
        old_b = ref_mem[b_addr]; kb = known[b_addr];
        if (a_en) begin
          if (a_we && RM == 2)      begin res = last_a; rc = care_a; end
          else if (a_we && RM == 1) begin res = lane_merge(old_a, a_din, a_be); rc = ka || (a_be == '1); end
          else                      begin res = old_a; rc = ka; end
          exp_a_q.push_back({rc, res, t + 32'(LAT)});
          last_a = res; care_a = rc;
        end
        if (b_en) begin
          if (b_we && RM == 2)      begin res = last_b; rc = care_b; end
          else if (b_we && RM == 1) begin res = lane_merge(old_b, b_din, b_be); rc = kb || (b_be == '1); end
          else                      begin res = old_b; rc = kb; end
          exp_b_q.push_back({rc, res, t + 32'(LAT)});
          last_b = res; care_b = rc;
        end
        if (a_en && a_we && b_en && b_we && a_addr == b_addr)
          exp_c_q.push_back({1'b1, DW'(0), t + 32'd5});
        // B first, then A on top: A owns every lane it enables.
        if (b_en && b_we) begin
          ref_mem[b_addr] = lane_merge(ref_mem[b_addr], b_din, b_be);
          if (b_be == '1) known[b_addr] = 1'b1;
        end
        if (a_en && a_we) begin
          ref_mem[a_addr] = lane_merge(ref_mem[a_addr], a_din, a_be);
          if (a_be == '1) known[a_addr] = 1'b1;
        end
      end
    end

    // Monitor: sampled on the falling edge, pops whatever result is due this cycle.
    always @(negedge clk) begin : mon
      logic [EW-1:0] e;
      logic          ev;
      if (!rst_n) begin
        check("rst_a_dout", gi, a_dout, '0);
        check("rst_b_dout", gi, b_dout, '0);
        check("rst_a_valid", gi, DW'(a_valid), '0);
        check("rst_b_valid", gi, DW'(b_valid), '0);
        check("rst_collision", gi, DW'(collision), '0);
      end else begin
        ev = (exp_a_q.size() != 0) && (exp_a_q[0][31:0] == 32'($time));
        check("a_valid", gi, DW'(a_valid), DW'(ev));
        if (ev) begin
          e = exp_a_q.pop_front();
          shown_a = e[DW+31:32]; shown_a_care = e[EW-1];
        end
        if (shown_a_care) check("a_dout", gi, a_dout, shown_a);

        ev = (exp_b_q.size() != 0) && (exp_b_q[0][31:0] == 32'($time));
        check("b_valid", gi, DW'(b_valid), DW'(ev));
        if (ev) begin
          e = exp_b_q.pop_front();
          shown_b = e[DW+31:32]; shown_b_care = e[EW-1];
        end
        if (shown_b_care) check("b_dout", gi, b_dout, shown_b);

        ev = (exp_c_q.size() != 0) && (exp_c_q[0][31:0] == 32'($time));
        check("collision", gi, DW'(collision), DW'(ev));
        if (ev) e = exp_c_q.pop_front();
      end
    end

    always @(posedge done) begin
      check("a_drain", gi, DW'(exp_a_q.size()), '0);
      check("b_drain", gi, DW'(exp_b_q.size()), '0);
      check("c_drain", gi, DW'(exp_c_q.size()), '0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ae, input logic awe, input logic [NB-1:0] abe,
                       input logic [AW-1:0] aad, input logic [DW-1:0] ad,
                       input logic ben, input logic bwe, input logic [NB-1:0] bbe,
                       input logic [AW-1:0] bad_addr, input logic [DW-1:0] bd);
    a_en = ae;  a_we = awe; a_be = abe; a_addr = aad;      a_din = ad;
    b_en = ben; b_we = bwe; b_be = bbe; b_addr = bad_addr; b_din = bd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic drive_random(input int n);
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), NB'($urandom),
            ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), NB'($urandom),
            ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)), $urandom);
    end
  endtask

  // Holds reset for n cycles with the current inputs still applied.
  task automatic reset_pulse(input int n);
    #2 rst_n = 1'b0;
    repeat (n) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    done  = 1'b0;
    rst_n = 1'b1;
    a_en = 1'b1; a_we = 1'b0; a_be = '0; a_addr = 8'h10; a_din = '0;
    b_en = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0;    b_din = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(2);

    for (int i = 0; i < DEPTH / 2; i++)
      drive(1, 1, '1, AW'(2 * i), $urandom, 1, 1, '1, AW'(2 * i + 1), $urandom);
    idle(2);

    // Byte-enable merge, then B reads the merged word.
    drive(1, 1, 4'hF, 8'h05, 32'h11223344, 0, 0, '0, '0, '0);
    drive(1, 1, 4'h5, 8'h05, 32'hAABBCCDD, 0, 0, '0, '0, '0);
    drive(0, 0, '0, '0, '0, 1, 0, '0, 8'h05, '0);
    idle(2);

    // Same-port read-during-write, then a plain read, then a be=0 write.
    drive(1, 1, 4'hF, 8'h05, 32'h11223344, 0, 0, '0, '0, '0);
    drive(1, 1, 4'hF, 8'h05, 32'hFFFFFFFF, 0, 0, '0, '0, '0);
    drive(1, 0, '0, 8'h05, '0, 0, 0, '0, '0, '0);
    drive(1, 1, 4'h0, 8'h05, 32'h01020304, 1, 1, 4'h0, 8'h06, 32'h05060708);
    idle(3);

    // Dual write to one address, then read back on both ports.
    drive(1, 1, 4'h1, 8'h20, 32'h000000AA, 1, 1, 4'hF, 8'h20, 32'hBBBBBBBB);
    drive(1, 0, '0, 8'h20, '0, 1, 0, '0, 8'h20, '0);
    drive(1, 1, 4'hF, 8'h21, 32'h0BADF00D, 1, 1, 4'hF, 8'h22, 32'h600DCAFE);
    drive(1, 0, '0, 8'h22, '0, 1, 0, '0, 8'h21, '0);
    idle(3);

    // Cross-port read while the other port writes.
    drive(1, 1, 4'hF, 8'h30, 32'h12345678, 0, 0, '0, '0, '0);
    drive(1, 1, 4'hF, 8'h30, 32'hCAFEF00D, 1, 0, '0, 8'h30, '0);
    drive(0, 0, '0, '0, '0, 1, 0, '0, 8'h30, '0);
    idle(3);

    // Back-to-back reads cut by reset; a write issued during reset must not land.
    drive(1, 0, '0, 8'h05, '0, 1, 0, '0, 8'h30, '0);
    a_addr = 8'h20;
    #2 rst_n = 1'b0;
    @(negedge clk);
    drive(1, 1, 4'hF, 8'h05, 32'hDEADBEEF, 1, 1, 4'hF, 8'h30, 32'hFEEDFACE);
    a_en = 1'b0; b_en = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(2);
    drive(1, 0, '0, 8'h05, '0, 1, 0, '0, 8'h30, '0);
    idle(3);

    drive_random(250);
    reset_pulse(2);
    drive_random(250);
    idle(6);

    done = 1'b1;
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_port_byte_ram.md
Name: dual_port_byte_ram

Overview:
- True dual-port synchronous RAM: two independent read/write ports (A, B) on one clock.
- Adds per-byte write enables, a selectable read-during-write mode, an optional output register stage, per-port read-valid flags and same-address write-collision detection.
- Generalised successor of the team's single-port RAM; used as the shared buffer behind DMA and interface blocks that need concurrent access.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data), 2 = no-change (dout holds).
- OUT_REG, 0, 1 inserts an extra output register; read latency becomes 2.

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- a_en, input, 1, port A access enable.
- a_we, input, 1, port A write (valid only with a_en).
- a_be, input, NB, port A byte enables for writes.
- a_addr, input, ADDR_WIDTH, port A address.
- a_din, input, DATA_WIDTH, port A write data.
- a_dout, output, DATA_WIDTH, port A read data.
- a_valid, output, 1, a_dout carries the result of an access.
- b_en, b_we, b_be, b_addr, b_din, b_dout, b_valid: same as A, for port B.
- collision, output, 1, one-cycle pulse: both ports wrote the same address.

Behaviour:
- Reset (async, rst_n low): a_dout = b_dout = 0, a_valid = b_valid = 0, collision = 0, output pipeline cleared. Memory array is not reset. While rst_n is low, writes are suppressed.
- Access condition: a port accesses the array on a rising edge when en = 1. A write needs we = 1, and byte lane i is written only where be[i] = 1. be = 0 with we = 1 is a read-free no-op write; dout behaves per RDW_MODE.
- Latency, OUT_REG = 0:
  - Access at edge N gives dout/valid updated at edge N.
  - Visible in cycle N+1; valid high for exactly that cycle per access.
- Latency, OUT_REG = 1:
  - Data and valid pass through a second register, visible in cycle N+2.
  - Back-to-back accesses give one result per cycle.
- When en = 0: valid deasserts at the corresponding pipeline stage; dout holds its last value.
- Same-port read-during-write:
  - Mode 0: dout = old word.
  - Mode 1: dout = old word with enabled bytes replaced by din.
  - Mode 2: dout unchanged, but valid still pulses.
- Cross-port: a read on one port to an address being written by the other port in the same cycle returns the old word, regardless of RDW_MODE.
- Dual write, same address, same cycle:
  - Per byte lane, A wins where a_be = 1.
  - B's lanes are written where b_be = 1 and a_be = 0.
  - collision asserts in the following cycle for one cycle, even if the byte enables do not overlap.
- Different-address dual writes: independent, no collision.
- Address wrap: none; addresses are modulo depth by width.
- Reset mid-operation: pending pipeline results are discarded; valid is 0 after release until a new access.

Decomposition:
- Package dpram_pkg:
  - RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1, RDW_NO_CHANGE = 2.
  - Function computing the byte-merged word from old, din and be.
- Sub-module dpram_out_stage (instantiated per port): holds the dout/valid register plus the optional OUT_REG stage, with async reset.
- Top: array, write arbitration, collision detect.

Test Plan:
- Reset then reads:
  - Stimulus: assert rst_n low, release; a_en = 1 reading addr 0x10.
  - Response: a_dout = 0 and a_valid = 0 during reset. After the access, a_valid pulses one cycle later.
- Byte-enable write/read:
  - Stimulus: A writes 0x11223344 to 0x05 with be = 1111; then writes 0xAABBCCDD with be = 0101; then B reads 0x05.
  - Response: b_dout = 0x11BB33DD at latency 1; at latency 2 with OUT_REG = 1.
- RDW modes:
  - Stimulus: with 0x05 = 0x11223344, A writes 0xFFFFFFFF (be = 1111) while reading 0x05.
  - Response: mode 0 gives 0x11223344; mode 1 gives 0xFFFFFFFF; mode 2 leaves a_dout at its prior value with a_valid = 1.
- Dual-write collision:
  - Stimulus: A writes 0x000000AA (be = 0001), B writes 0xBBBBBBBB (be = 1111), both to 0x20, same cycle.
  - Response: word = 0xBBBBBBAA; collision = 1 for exactly the next cycle. Different addresses give collision = 0.
- Cross-port read during write:
  - Stimulus: 0x30 = 0x12345678; A writes 0xCAFEF00D to 0x30 while B reads 0x30.
  - Response: b_dout = 0x12345678; next-cycle B read returns 0xCAFEF00D.
- Reset mid-stream:
  - Stimulus: OUT_REG = 1, back-to-back reads, rst_n pulsed low between them.
  - Response: valid = 0 immediately and no stale result emerges after release. A write issued during reset leaves memory unchanged.
